// File: rtl/wrr_packet_arbiter_pkg.sv
// Shared crossbar definitions: arbiter state encoding and small helpers.
// Imported by the packet arbiter and its rotating-priority picker.
package wrr_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int CREDIT_MAX_W = 16;

  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A zero quantum would starve its source, so it grants one packet.
  function automatic logic [CREDIT_MAX_W-1:0] weight_to_credit(
    input logic [CREDIT_MAX_W-1:0] w
  );
    return (w == '0) ? CREDIT_MAX_W'(1) : w;
  endfunction

endpackage

// File: rtl/wrr_packet_arbiter_rr_pick.sv
// Rotating-priority first-one finder: first set request at or after ptr,
// wrapping past the top index.
module rr_pick
  import wrr_packet_arbiter_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = clog2_safe(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  always_comb begin : p_scan
    int j;
    j       = 0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_found && i_req[j]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Packet-granular weighted round-robin arbiter for one crossbar master port.
// Grant is held through last; each source gets up to weight packets per turn.
module wrr_packet_arbiter
  import wrr_packet_arbiter_pkg::*;
#(
  parameter int S_DATA_COUNT = 5,
  parameter int T_ID___WIDTH = clog2_safe(S_DATA_COUNT),
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [S_DATA_COUNT-1:0]            req_i,
  input  logic [S_DATA_COUNT-1:0]            last_i,
  input  logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i,
  input  logic                               m_ready_i,
  output logic [S_DATA_COUNT-1:0]            grant_o,
  output logic [T_ID___WIDTH-1:0]            id_o,
  output logic                               valid_o,
  output logic                               last_o,
  output logic [S_DATA_COUNT-1:0]            s_ready_o,
  output logic                               busy_o
);

  localparam int S  = S_DATA_COUNT;
  localparam int IW = T_ID___WIDTH;
  localparam int W  = WEIGHT_WIDTH;

  state_e          r_state;
  state_e          w_state_nx;
  logic [IW-1:0]   r_sel;
  logic [IW-1:0]   w_sel_nx;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_nx;
  logic [IW-1:0]   w_ptr_inc;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_found;
  logic [W-1:0]    r_credit;
  logic [W-1:0]    w_credit_nx;
  logic [W-1:0]    w_weight_sel;
  logic [W-1:0]    w_credit_load;
  logic            r_boundary;
  logic            w_boundary_nx;
  logic [S-1:0]    r_grant;
  logic [S-1:0]    w_grant_nx;
  logic            w_busy;
  logic            w_valid;
  logic            w_last;
  logic            w_hs;
  logic            w_pkt_end;
  logic            w_release;

  rr_pick #(
    .N  (S),
    .IW (IW)
  ) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_weight_sel  = weight_i[int'(w_pick_idx)*W +: W];
  assign w_credit_load = W'(weight_to_credit(CREDIT_MAX_W'(w_weight_sel)));
  assign w_ptr_inc     = (r_sel == IW'(S-1)) ? '0 : r_sel + 1'b1;

  assign w_busy    = (r_state == ST_LOCK);
  assign w_valid   = w_busy & req_i[r_sel];
  assign w_last    = w_busy & last_i[r_sel];
  assign w_hs      = w_valid & m_ready_i;
  assign w_pkt_end = w_hs & w_last;

  assign grant_o   = r_grant;
  assign id_o      = r_sel;
  assign valid_o   = w_valid;
  assign last_o    = w_last;
  assign s_ready_o = r_grant & {S{m_ready_i}};
  assign busy_o    = w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_credit   <= '0;
      r_boundary <= 1'b0;
      r_grant    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_sel      <= w_sel_nx;
      r_ptr      <= w_ptr_nx;
      r_credit   <= w_credit_nx;
      r_boundary <= w_boundary_nx;
      r_grant    <= w_grant_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_sel_nx      = r_sel;
    w_ptr_nx      = r_ptr;
    w_credit_nx   = r_credit;
    w_boundary_nx = r_boundary;
    w_grant_nx    = r_grant;
    w_release     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nx    = ST_LOCK;
          w_sel_nx      = w_pick_idx;
          w_grant_nx    = S'(1) << w_pick_idx;
          w_credit_nx   = w_credit_load;
          w_boundary_nx = 1'b0;
        end
      end
      ST_LOCK: begin
        // Packet end outranks the boundary decision in the same cycle.
        if (w_pkt_end) begin
          if (r_credit <= W'(1)) begin
            w_release = 1'b1;
          end else begin
            w_credit_nx   = r_credit - 1'b1;
            w_boundary_nx = 1'b1;
          end
        end else if (r_boundary) begin
          if (req_i[r_sel]) begin
            w_boundary_nx = 1'b0;
          end else begin
            w_release = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    if (w_release) begin
      w_state_nx    = ST_IDLE;
      w_sel_nx      = '0;
      w_grant_nx    = '0;
      w_ptr_nx      = w_ptr_inc;
      w_credit_nx   = '0;
      w_boundary_nx = 1'b0;
    end
  end

endmodule
